// File: rtl/percept_tx_arb_pkg.sv
// percept_tx_arb_pkg: shared types and defaults for the percept tx arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, GUARD)
//   N_DEF, GAP_DEF, TIMEOUT_DEF : default percept count, idle gap, grant limit
//   cnt_w()     : counter/index width for a range of n values (minimum 1 bit);
//                 used for the owner index and the GAP and watchdog counters
package percept_tx_arb_pkg;

  localparam int unsigned N_DEF       = 256;
  localparam int unsigned GAP_DEF     = 16;
  localparam int unsigned TIMEOUT_DEF = 2_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arb_state_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/percept_tx_arb_rr_pick.sv
// percept_tx_arb_rr_pick: combinational rotating priority encoder.
// Finds the first set request bit searching upward from last+1, wrapping
// from N-1 back to 0, so the previous grantee has the lowest priority.
//   req  in  N   request vector
//   last in  AW  index of the previous grantee
//   sel  out AW  selected index (0 when nothing requested)
//   any  out 1   at least one request present
module percept_tx_arb_rr_pick
  import percept_tx_arb_pkg::*;
#(
  parameter int unsigned  N  = N_DEF,
  localparam int unsigned AW = cnt_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] sel,
  output logic          any
);

  logic [AW-1:0] idx;

  // Walk the N positions in rotation order; the first hit wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = AW'((32'(last) + i) % N);
      if (!any && req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/percept_tx_arbiter.sv
// percept_tx_arbiter: round-robin owner of the shared percept UART tx pin.
// Grants one requesting percept at a time, muxes its serial output onto tx
// through one register, and forces GAP idle-high cycles between frames.
// Optional watchdog: define PERCEPT_TX_ARB_TIMEOUT_EN to cap a grant at
// TIMEOUT cycles; without it a grant ends only on done or request drop.
//   clk, rst          clock, synchronous active-high reset
//   req[N]            per-percept level request
//   done[N]           per-percept end-of-frame pulse
//   percept_tx[N]     per-percept serial tx
//   grant[N]          one-hot grant (registered)
//   owner[AW]         current/last grantee index
//   busy              high in GRANT or GUARD
//   timeout           one-cycle pulse when the watchdog ends a grant
//   tx                arbitrated serial line, idle high
module percept_tx_arbiter
  import percept_tx_arb_pkg::*;
#(
  parameter int unsigned  N       = N_DEF,
  parameter int unsigned  GAP     = GAP_DEF,
  parameter int unsigned  TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned AW      = cnt_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  input  logic [N-1:0]  percept_tx,
  output logic [N-1:0]  grant,
  output logic [AW-1:0] owner,
  output logic          busy,
  output logic          timeout,
  output logic          tx
);

  localparam int unsigned GW = cnt_w(GAP);

  arb_state_e    state, state_d;
  logic [N-1:0]  grant_d;
  logic [AW-1:0] owner_d, last, last_d, sel;
  logic          any, busy_d, timeout_d, tx_d, expire;
  logic [GW-1:0] gap_cnt, gap_d;

  percept_tx_arb_rr_pick #(.N(N)) u_rr_pick (
    .req  (req),
    .last (last),
    .sel  (sel),
    .any  (any)
  );

`ifdef PERCEPT_TX_ARB_TIMEOUT_EN
  localparam int unsigned TW = cnt_w(TIMEOUT);
  logic [TW-1:0] timer;

  // Counts GRANT cycles; zero in the first cycle of every grant.
  always_ff @(posedge clk) begin
    if (rst)                  timer <= '0;
    else if (state == GRANT)  timer <= timer + TW'(1);
    else                      timer <= '0;
  end

  assign expire = (state == GRANT) && (timer == TW'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign expire             = 1'b0;
`endif

  // Next state and next output values.
  always_comb begin
    state_d   = state;
    grant_d   = grant;
    owner_d   = owner;
    last_d    = last;
    busy_d    = busy;
    timeout_d = 1'b0;
    tx_d      = 1'b1;
    gap_d     = gap_cnt;
    case (state)
      IDLE: begin
        busy_d  = 1'b0;
        grant_d = '0;
        gap_d   = '0;
        if (any) begin
          state_d = GRANT;
          grant_d = N'(1) << sel;
          owner_d = sel;
          last_d  = sel;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        tx_d = percept_tx[owner];
        // A frame end beats a coincident watchdog expiry.
        if (done[owner] || !req[owner] || expire) begin
          state_d   = GUARD;
          grant_d   = '0;
          tx_d      = 1'b1;
          gap_d     = '0;
          timeout_d = expire && !done[owner];
        end
      end
      GUARD: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      last    <= AW'(N - 1);
      busy    <= 1'b0;
      timeout <= 1'b0;
      tx      <= 1'b1;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      owner   <= owner_d;
      last    <= last_d;
      busy    <= busy_d;
      timeout <= timeout_d;
      tx      <= tx_d;
      gap_cnt <= gap_d;
    end
  end

endmodule

// File: tb/tb_percept_tx_arbiter.sv
// Bench for percept_tx_arbiter: batches of requests are issued, a rotation
// model predicts the grant order and grant lengths into a scoreboard, and a
// negedge monitor checks every cycle of the DUT outputs against it.
module tb_percept_tx_arbiter;

  localparam int N       = 256;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 100;
  localparam int BIG     = 1_000_000;
`ifdef PERCEPT_TX_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, done, percept_tx, grant;
  logic [7:0]   owner;
  logic         busy, timeout, tx;

  always #5 clk = ~clk;

  percept_tx_arbiter #(.N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .percept_tx (percept_tx),
    .grant      (grant),
    .owner      (owner),
    .busy       (busy),
    .timeout    (timeout),
    .tx         (tx)
  );

  typedef struct { int owner; int len; bit tmo; bit gap_chk; } exp_t;
  typedef struct { int len; bit withdraw; } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    b_ids[$];
  int    b_frames[$];
  int    rem_m[N];
  int    rem_drv[N];
  int    m_last;
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  bit    abort_run = 1'b0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every cycle against the scoreboard entry of the grant in flight.
  initial begin : monitor
    bit   prev_g, g_any;
    int   zero_cnt, grant_len;
    exp_t cur;
    logic last_ptx;
    prev_g = 1'b0; zero_cnt = BIG; grant_len = 0; last_ptx = 1'b1;
    cur = '{owner: 0, len: 0, tmo: 1'b0, gap_chk: 1'b0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_g = 1'b0; zero_cnt = BIG; grant_len = 0;
      end else begin
        g_any = |grant;
        if (g_any && !prev_g) begin
          if (exp_q.size() == 0) begin
            check("grant_unexpected", grant, '0);
            cur = '{owner: 0, len: 0, tmo: 1'b0, gap_chk: 1'b0};
          end else begin
            cur = exp_q.pop_front();
            check("owner", N'(owner), N'(cur.owner));
            check("grant_onehot", grant, N'(1) << cur.owner);
            if (cur.gap_chk) check("gap_len", N'(zero_cnt), N'(GAP + 1));
          end
          grant_len = 0;
        end
        if (g_any) begin
          grant_len++;
          check("busy_grant", N'(busy), N'(1));
          check("timeout_quiet", N'(timeout), N'(0));
          check("tx_mirror", N'(tx), N'(prev_g ? last_ptx : 1'b1));
          last_ptx = percept_tx[8'(cur.owner)];
        end else begin
          if (prev_g) begin
            zero_cnt = 1;
            check("grant_len", N'(grant_len), N'(cur.len));
            check("timeout_pulse", N'(timeout), N'(cur.tmo));
          end else begin
            if (zero_cnt < BIG) zero_cnt++;
            check("timeout_quiet", N'(timeout), N'(0));
          end
          check("tx_idle", N'(tx), N'(1));
          check("busy_guard", N'(busy), N'(zero_cnt <= GAP));
        end
        prev_g = g_any;
      end
    end
  end

  // Plays the granted percepts: random serial data, then done or withdrawal.
  task automatic serve(input int nframes);
    int    budget, k, nz;
    plan_t p;
    for (int f = 0; f < nframes && !abort_run; f++) begin
      budget = 0;
      while (grant == '0 && budget < 400) begin
        tick();
        budget++;
      end
      if (grant == '0) begin
        check("grant_wait", grant, N'(1));
        abort_run = 1'b1;
        return;
      end
      k = -1;
      for (int i = 0; i < N; i++) if (grant[8'(i)] && k < 0) k = i;
      p = plan_q.pop_front();
      for (int c = 1; c <= p.len; c++) begin
        for (int w = 0; w < N / 32; w++) percept_tx[w*32 +: 32] = $urandom;
        done = '0;
        if ($urandom_range(0, 3) == 0) begin
          nz = $urandom_range(0, N - 1);
          if (nz != k) done[8'(nz)] = 1'b1;
        end
        if (c == p.len) begin
          if (p.withdraw) req[8'(k)] = 1'b0;
          else            done[8'(k)] = 1'b1;
        end
        tick();
      end
      done = '0;
      rem_drv[k]--;
      if (rem_drv[k] <= 0) req[8'(k)] = 1'b0;
    end
  endtask

  // Predicts the grant sequence for the batch in b_ids/b_frames, then runs it.
  task automatic run_batch(input int force_len);
    int  total, best, bestd, d, len, el;
    bit  first, wdr;
    if (abort_run) return;
    total = 0;
    foreach (b_ids[i]) begin
      rem_m[b_ids[i]]   += b_frames[i];
      rem_drv[b_ids[i]] += b_frames[i];
      total             += b_frames[i];
    end
    first = 1'b1;
    for (int n = 0; n < total; n++) begin
      best = -1; bestd = N;
      for (int j = 0; j < N; j++) begin
        d = (j - m_last - 1 + 2 * N) % N;
        if (rem_m[j] > 0 && d < bestd) begin best = j; bestd = d; end
      end
      rem_m[best]--;
      if (force_len > 0)                 len = force_len;
      else if ($urandom_range(0, 11) == 0) len = $urandom_range(TIMEOUT - 2, TIMEOUT + 4);
      else if ($urandom_range(0, 9) < 7)   len = $urandom_range(1, 12);
      else                                 len = $urandom_range(13, 40);
      wdr = (rem_m[best] == 0) && ($urandom_range(0, 4) == 0) && (len != TIMEOUT);
      el  = (WD && len > TIMEOUT) ? TIMEOUT : len;
      exp_q.push_back('{owner: best, len: el, tmo: WD && len > TIMEOUT, gap_chk: !first});
      plan_q.push_back('{len: len, withdraw: wdr});
      m_last = best;
      first  = 1'b0;
    end
    foreach (b_ids[i]) req[8'(b_ids[i])] = 1'b1;
    serve(total);
    repeat (GAP + 3 + $urandom_range(0, 4)) tick();
  endtask

  initial begin : global_limit
    #3_000_000;
    checks++;
    failures++;
    $display("FAIL global_limit: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int budget, n_ids, id;
    rst = 1'b1; req = '0; done = '0; percept_tx = '1; m_last = N - 1;
    foreach (rem_m[i]) begin rem_m[i] = 0; rem_drv[i] = 0; end
    repeat (3) tick();
    check("rst_grant", grant, '0);
    check("rst_owner", N'(owner), '0);
    check("rst_busy", N'(busy), '0);
    check("rst_timeout", N'(timeout), '0);
    check("rst_tx", N'(tx), N'(1));
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    b_ids = '{5};      b_frames = '{1};    run_batch(0);
    b_ids = '{3};      b_frames = '{1};    run_batch(0);
    b_ids = '{3, 7};   b_frames = '{1, 1}; run_batch(0);
    b_ids = '{255};    b_frames = '{1};    run_batch(0);
    b_ids = '{0, 255}; b_frames = '{1, 1}; run_batch(0);
    b_ids = '{9};      b_frames = '{1};    run_batch(TIMEOUT + 3);
    b_ids = '{9};      b_frames = '{1};    run_batch(TIMEOUT);
    b_ids = '{20, 21}; b_frames = '{2, 1}; run_batch(0);

    // Reset in the middle of a grant to owner 12.
    if (!abort_run) begin
      mon_en = 1'b0;
      tick();
      req[12] = 1'b1;
      budget = 0;
      while (grant == '0 && budget < 50) begin tick(); budget++; end
      check("rst_pre_owner", N'(owner), N'(12));
      repeat (5) begin
        for (int w = 0; w < N / 32; w++) percept_tx[w*32 +: 32] = $urandom;
        tick();
      end
      percept_tx = '0;
      rst = 1'b1;
      tick();
      check("rst_mid_grant", grant, '0);
      check("rst_mid_tx", N'(tx), N'(1));
      check("rst_mid_owner", N'(owner), '0);
      check("rst_mid_busy", N'(busy), '0);
      check("rst_mid_timeout", N'(timeout), '0);
      req = '0;
      rst = 1'b0;
      m_last = N - 1;
      tick();
      mon_en = 1'b1;
      tick();
      b_ids = '{12, 0}; b_frames = '{1, 1}; run_batch(0);
    end

    for (int b = 0; b < 30 && !abort_run; b++) begin
      b_ids = {}; b_frames = {};
      n_ids = $urandom_range(1, 5);
      for (int i = 0; i < n_ids; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: id = 0;
            1: id = 1;
            2: id = N - 2;
            default: id = N - 1;
          endcase
        end else begin
          id = $urandom_range(0, N - 1);
        end
        if (rem_m[id] == 0 && !(id inside {b_ids})) begin
          b_ids.push_back(id);
          b_frames.push_back(($urandom_range(0, 2) == 0) ? 2 : 1);
        end
      end
      run_batch(0);
    end

    check("scoreboard_drain", N'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
